// File: rtl/main_buffer_pkg.sv
// Shared types and constants for the main input buffer load controller.
package main_buffer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } load_state_e;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_CIRC    = 1'b1;

endpackage

// File: rtl/main_buffer_load_ctrl_window_counter.sv
// Up-counter over an inclusive window: loads a value, counts on i_inc, and
// wraps back to the load value when incremented at the terminal count.
module window_counter #(
  parameter int W = 3
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic [W-1:0] i_end,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == i_end);

  // Wrap compare wins over +1, so a full-range window never overflows.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_inc) begin
      r_cnt <= o_tc ? i_load_val : r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/main_buffer_load_ctrl.sv
// Load controller for the main input buffer: walks an address window over a
// number of rows, one-shot or circular, with back-pressure, abort and config check.
module main_buffer_load_ctrl
  import main_buffer_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int ROW_W  = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_clear,
  input  logic              i_circ_mode,
  input  logic [ADDR_W-1:0] i_start_addr,
  input  logic [ADDR_W-1:0] i_end_addr,
  input  logic [ROW_W-1:0]  i_num_rows,
  input  logic              i_in_valid,
  input  logic              i_buf_full,
  output logic              o_in_ready,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [ROW_W-1:0]  o_row_idx,
  output logic              o_cout,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  load_state_e       r_state, w_next;
  logic [ADDR_W-1:0] r_start_addr, r_end_addr;
  logic [ROW_W-1:0]  r_num_rows;
  logic              r_circ, r_err, r_done;

  logic              w_legal, w_start_idle, w_go, w_accept;
  logic              w_addr_tc, w_row_tc, w_addr_inc, w_row_inc;
  logic [ADDR_W-1:0] w_addr_ld_val;
  logic [ROW_W-1:0]  w_row_end;

  assign w_legal      = (i_start_addr <= i_end_addr) && (i_num_rows != '0);
  assign w_start_idle = i_start && (r_state == IDLE);
  assign w_go         = w_start_idle && w_legal && !i_clear;

  assign o_in_ready = (r_state == LOAD) && !i_buf_full;
  assign o_wr_en    = i_in_valid && o_in_ready;
  assign w_accept   = o_wr_en && !i_clear;
  assign o_cout     = o_wr_en && w_addr_tc;
  assign o_busy     = (r_state != IDLE);
  assign o_done     = r_done;
  assign o_err      = r_err;

  // The counter's load input doubles as the wrap target, so feed the live
  // start address while idle and the latched one during the load.
  assign w_addr_ld_val = (r_state == IDLE) ? i_start_addr : r_start_addr;
  assign w_row_end     = r_num_rows - ROW_W'(1);

  assign w_addr_inc = w_accept;
  assign w_row_inc  = w_accept && w_addr_tc && !(w_row_tc && r_circ == MODE_ONESHOT);

  window_counter #(.W(ADDR_W)) u_addr_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_go),
    .i_load_val (w_addr_ld_val),
    .i_end      (r_end_addr),
    .i_inc      (w_addr_inc),
    .o_cnt      (o_wr_addr),
    .o_tc       (w_addr_tc)
  );

  window_counter #(.W(ROW_W)) u_row_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_go),
    .i_load_val ('0),
    .i_end      (w_row_end),
    .i_inc      (w_row_inc),
    .o_cnt      (o_row_idx),
    .o_tc       (w_row_tc)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (i_start) w_next = w_legal ? LOAD : DONE;
      LOAD: if (w_accept && w_addr_tc && w_row_tc && r_circ == MODE_ONESHOT) w_next = DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (i_clear) w_next = IDLE;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_start_addr <= '0;
      r_end_addr   <= '0;
      r_num_rows   <= '0;
      r_circ       <= MODE_ONESHOT;
    end else begin
      r_state <= w_next;
      r_done  <= (w_next == DONE);
      if (i_clear) begin
        r_err <= 1'b0;
      end else if (w_start_idle) begin
        r_err <= !w_legal;
      end
      if (w_go) begin
        r_start_addr <= i_start_addr;
        r_end_addr   <= i_end_addr;
        r_num_rows   <= i_num_rows;
        r_circ       <= i_circ_mode;
      end
    end
  end

endmodule

// File: tb/tb_main_buffer_load_ctrl.sv
// Directed bench for main_buffer_load_ctrl with hand-computed expectations.
module tb_main_buffer_load_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, clear, circ_mode, in_valid, buf_full;
  logic [2:0] start_addr, end_addr;
  logic [1:0] num_rows;
  logic       in_ready, wr_en, cout, busy, done, err;
  logic [2:0] wr_addr;
  logic [1:0] row_idx;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  main_buffer_load_ctrl #(.ADDR_W(3), .ROW_W(2)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_clear      (clear),
    .i_circ_mode  (circ_mode),
    .i_start_addr (start_addr),
    .i_end_addr   (end_addr),
    .i_num_rows   (num_rows),
    .i_in_valid   (in_valid),
    .i_buf_full   (buf_full),
    .o_in_ready   (in_ready),
    .o_wr_en      (wr_en),
    .o_wr_addr    (wr_addr),
    .o_row_idx    (row_idx),
    .o_cout       (cout),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic cfg(input logic [2:0] sa, input logic [2:0] ea, input logic [1:0] nr, input logic cm);
    start_addr = sa;
    end_addr   = ea;
    num_rows   = nr;
    circ_mode  = cm;
  endtask

  bit full_pat  [11] = '{0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0};
  bit valid_pat [11] = '{1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1};

  initial begin
    int k;
    int nwr;
    rst = 1'b1; start = 0; clear = 0; in_valid = 0; buf_full = 0;
    cfg(3'd0, 3'd0, 2'd0, 1'b0);
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_row_idx", row_idx, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_in_ready", in_ready, 0);
    tick();
    rst = 1'b0;
    tick();

    // One-shot, window 1..4, 2 rows, in_valid held high
    start = 1; in_valid = 1; cfg(3'd1, 3'd4, 2'd2, 1'b0);
    settle();
    chk("t1_idle_wr_en", wr_en, 0);
    chk("t1_idle_ready", in_ready, 0);
    tick();
    start = 0;
    for (int b = 0; b < 8; b++) begin
      settle();
      chk("t1_wr_en", wr_en, 1);
      chk("t1_wr_addr", wr_addr, 1 + (b % 4));
      chk("t1_row_idx", row_idx, b / 4);
      chk("t1_cout", cout, (b % 4) == 3);
      chk("t1_done_early", done, 0);
      tick();
    end
    settle();
    chk("t1_done", done, 1);
    chk("t1_done_busy", busy, 1);
    chk("t1_done_wr_en", wr_en, 0);
    chk("t1_done_row", row_idx, 1);
    tick();
    settle();
    chk("t1_done_pulse", done, 0);
    chk("t1_busy_low", busy, 0);
    in_valid = 0;
    tick();

    // Same load with stalls from buf_full and a dropped in_valid
    start = 1; cfg(3'd1, 3'd4, 2'd2, 1'b0);
    tick();
    start = 0;
    nwr = 0;
    for (int c = 0; c < 11; c++) begin
      in_valid = valid_pat[c];
      buf_full = full_pat[c];
      settle();
      chk("t2_in_ready", in_ready, !full_pat[c]);
      chk("t2_wr_en", wr_en, valid_pat[c] && !full_pat[c]);
      chk("t2_wr_addr", wr_addr, 1 + (nwr % 4));
      if (valid_pat[c] && !full_pat[c]) begin
        chk("t2_cout", cout, (nwr % 4) == 3);
        nwr++;
      end
      tick();
    end
    in_valid = 0; buf_full = 0;
    settle();
    chk("t2_writes", nwr, 8);
    chk("t2_done", done, 1);
    tick();
    chk("t2_idle", busy, 0);

    // Circular, full range 0..7, 1 row, 20 beats
    start = 1; cfg(3'd0, 3'd7, 2'd1, 1'b1);
    tick();
    start = 0; in_valid = 1;
    for (int b = 0; b < 20; b++) begin
      settle();
      chk("t3_wr_addr", wr_addr, b % 8);
      chk("t3_cout", cout, (b % 8) == 7);
      chk("t3_row_idx", row_idx, 0);
      chk("t3_done", done, 0);
      tick();
    end
    chk("t3_busy", busy, 1);
    in_valid = 0; clear = 1;
    tick();
    clear = 0;
    chk("t3_clear_idle", busy, 0);
    chk("t3_clear_done", done, 0);

    // Illegal config: reversed window
    start = 1; in_valid = 1; cfg(3'd5, 3'd2, 2'd1, 1'b0);
    settle();
    chk("t4a_wr_en", wr_en, 0);
    tick();
    start = 0;
    chk("t4a_err", err, 1);
    chk("t4a_done", done, 1);
    chk("t4a_wr_en_done", wr_en, 0);
    tick();
    chk("t4a_done_pulse", done, 0);
    chk("t4a_idle", busy, 0);
    chk("t4a_err_sticky", err, 1);

    // Illegal config: zero rows
    start = 1; cfg(3'd0, 3'd3, 2'd0, 1'b0);
    tick();
    start = 0;
    chk("t4b_err", err, 1);
    chk("t4b_done", done, 1);
    chk("t4b_wr_en", wr_en, 0);
    tick();
    chk("t4b_idle", busy, 0);

    // Legal start clears err
    start = 1; in_valid = 0; cfg(3'd2, 3'd3, 2'd1, 1'b0);
    tick();
    start = 0;
    chk("t4c_err_clr", err, 0);
    chk("t4c_wr_addr", wr_addr, 2);
    in_valid = 1;
    tick();
    tick();
    chk("t4c_done", done, 1);
    in_valid = 0;
    tick();

    // clear mid-row at address 3, together with start and an accepted beat
    start = 1; cfg(3'd1, 3'd4, 2'd2, 1'b0);
    tick();
    start = 0; in_valid = 1;
    tick();
    tick();
    start = 1; clear = 1;
    settle();
    chk("t5_wr_addr", wr_addr, 3);
    chk("t5_wr_en", wr_en, 1);
    tick();
    start = 0; clear = 0;
    chk("t5_idle", busy, 0);
    chk("t5_ready", in_ready, 0);
    chk("t5_no_done", done, 0);
    tick();
    chk("t5_start_ignored", busy, 0);
    chk("t5_no_done2", done, 0);
    in_valid = 0;

    // Async reset between edges mid-load
    start = 1; cfg(3'd2, 3'd5, 2'd1, 1'b0);
    tick();
    start = 0; in_valid = 1;
    tick();
    #2;
    rst = 1;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_wr_addr", wr_addr, 0);
    chk("t6_row_idx", row_idx, 0);
    chk("t6_wr_en", wr_en, 0);
    chk("t6_in_ready", in_ready, 0);
    chk("t6_done", done, 0);
    tick();
    rst = 0; in_valid = 0;
    start = 1; cfg(3'd6, 3'd7, 2'd1, 1'b0);
    tick();
    start = 0;
    chk("t6_restart_addr", wr_addr, 6);
    chk("t6_restart_busy", busy, 1);
    k = 0;
    in_valid = 1;
    while (done !== 1'b1 && k < 10) begin
      tick();
      k++;
    end
    chk("t6_restart_done", done, 1);
    in_valid = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/main_buffer_load_ctrl.md
# main_buffer_load_ctrl

Parametrised load controller for the main input buffer. It generates write addresses and write strobes for one or more rows of data, over a programmable address window and a programmable row count. It supports a one-shot mode and a circular mode, source/buffer back-pressure, synchronous abort, and configuration error detection. It sits between the input-stream source and the main buffer write port, and it is started by the top-level controller FSM.

## Interface
- ADDR_W, 3, width of buffer write address and of start/end window bounds
- ROW_W, 2, width of the row-count configuration and row index
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a load; ignored unless IDLE
- clear  in  1  synchronous abort; returns to IDLE next edge
- circ_mode  in  1  0 = one-shot, 1 = circular (never finishes, rows repeat); sampled on start
- start_addr  in  ADDR_W  first address of window; sampled on start
- end_addr  in  ADDR_W  last address of window (inclusive); sampled on start
- num_rows  in  ROW_W  rows per load; sampled on start; 0 is illegal
- in_valid  in  1  source has a beat
- buf_full  in  1  buffer cannot accept a write this cycle
- in_ready  out  1  state==LOAD && !buf_full
- wr_en  out  1  in_valid && in_ready (combinational)
- wr_addr  out  ADDR_W  current address (registered)
- row_idx  out  ROW_W  current row (registered)
- cout  out  1  combinational; high on the accepted beat at end_addr (last beat of a row)
- busy  out  1  state != IDLE
- done  out  1  one-cycle registered pulse on completion
- err  out  1  sticky config error; cleared by next accepted start or by clear

## Operation
- States: IDLE, LOAD, DONE.
- IDLE -> LOAD on start with legal config (start_addr <= end_addr, num_rows != 0). The config is latched, wr_addr <= start_addr, row_idx <= 0, and err <= 0.
- IDLE -> DONE on start with illegal config. err <= 1. No writes occur.
- LOAD, beat accepted, wr_addr != end_addr: wr_addr <= wr_addr + 1.
- LOAD, beat accepted, wr_addr == end_addr: cout = 1 and wr_addr <= start_addr.
  - If row_idx == num_rows-1: in one-shot mode go to DONE. In circular mode set row_idx <= 0 and stay in LOAD.
  - Otherwise row_idx <= row_idx + 1.
- No accepted beat: hold all registers.
- DONE: done = 1 for exactly one cycle, then go to IDLE. wr_addr and row_idx hold their last values.
- clear in any state: next state IDLE, err <= 0. clear takes priority over start and over an accepted beat. A write strobe asserted in the same cycle as clear is still issued.
- start in LOAD or DONE is ignored.
- Arithmetic is unsigned. With start_addr = 0 and end_addr = 2^ADDR_W-1, the +1 never overflows past end_addr because the wrap-to-start compare takes precedence.
- Reset values: state IDLE, wr_addr 0, row_idx 0, err 0, done 0. Hence in_ready 0, wr_en 0, cout 0, busy 0.

## Timing
- Latency from start to first possible write is 1 cycle: in_ready rises the cycle after start.
- Throughput is 1 beat per cycle while in_valid && !buf_full.
- wr_addr is valid in the same cycle as wr_en. The buffer captures the write at the following edge.
- done rises the cycle after the last accepted beat of the last row.
- busy falls the cycle after done.
- Async reset mid-load aborts immediately. No partial state survives.
- in_valid may toggle freely. The block never depends on in_valid being held.

## Structure
- Package main_buffer_pkg holds:
  - the state enum `load_state_e` (IDLE, LOAD, DONE);
  - the mode constants MODE_ONESHOT/MODE_CIRC.
- The sub-module `window_counter` is an ADDR_W up-counter with:
  - a load value;
  - an inclusive terminal compare, producing the tc output;
  - wrap-to-load on terminal count.

  It is instantiated once for wr_addr. row_idx uses the same module with ROW_W, start 0 and end num_rows-1.
- The FSM and output logic live in the top module.

## Test plan
- Reset, then start with window 1..4, 2 rows, one-shot, and in_valid held high. Required response:
  - wr_addr sequence 1,2,3,4,1,2,3,4;
  - cout on the 4th and 8th beats;
  - done exactly one cycle after the 8th beat;
  - busy low one cycle later.
- Same load with buf_full asserted on beats 3 and 6, and in_valid dropped on beat 5. Required response: no wr_en while stalled, addresses continue correctly, 8 writes total.
- Circular mode with window 0..7 (full range) and 1 row, run for 20 beats. Required response: wr_addr wraps 7->0 with no overflow, cout every 8th beat, done never asserts.
- Illegal config: start_addr=5 with end_addr=2, and separately num_rows=0. Required response: no wr_en, err=1, done one pulse, back to IDLE. A later legal start clears err.
- clear asserted mid-row at wr_addr=3, in the same cycle as start and an accepted beat. Required response:
  - the write at 3 is issued;
  - the block is in IDLE next cycle;
  - start is ignored;
  - done is not pulsed.
- Async rst asserted mid-load between clock edges. Required response: all outputs at reset values immediately, and a new start after release begins from the newly sampled start_addr.
